i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs.sv | 271 +++++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
//
// I2C target (slave) with a bank of sixteen 8-bit registers. An I2C master
// addresses the block at SLV_ADDR, writes a register pointer and then either
// streams bytes into the bank or reads them back with a repeated START. The
// pointer auto-increments, wraps from 15 to 0 and persists across
// transactions. A local host can read any register combinationally and
// write one register per cycle.
//
// The bus is sampled with clk_i. SCL and SDA pass through a 2-flop
// synchroniser and one more register for edge detection, so every bus event
// acts 3 clk_i cycles after the pin moves. clk_i must run at least 16x SCL.
//
// Ports
//   clk_i        in   single clock for all logic
//   rst_i        in   synchronous reset, active high
//   scl_i        in   I2C SCL pad input (asynchronous)
//   sda_i        in   I2C SDA pad input (asynchronous)
//   sda_o        out  SDA output value, constant 0 (open drain)
//   sda_dir_o    out  1 = pull SDA low, 0 = release SDA
//   reg_addr_i   in   host register index
//   reg_wdata_i  in   host write data
//   reg_we_i     in   host write strobe
//   reg_rdata_o  out  combinational read of reg[reg_addr_i]
//   busy_o       out  high from address-match ACK until STOP
//   irq_o        out  one-cycle pulse at STOP when the transaction wrote
//                     at least one register over I2C
// ---------------------------------------------------------------------------
module i2c_target_regs #(
    parameter logic [6:0] SLV_ADDR = 7'h50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_dir_o,
    input  logic [3:0] reg_addr_i,
    input  logic [7:0] reg_wdata_i,
    input  logic       reg_we_i,
    output logic [7:0] reg_rdata_o,
    output logic       busy_o,
    output logic       irq_o
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } state_t;

    // -----------------------------------------------------------------------
    // Bus synchroniser and edge detection
    // -----------------------------------------------------------------------
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge; blocking here would collapse
    // the synchroniser chain into a single flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // An idle I2C bus is high, so the chain resets to 1 to avoid
            // seeing phantom edges when reset is released.
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;

    assign scl_rise  =  scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 &  scl_d;
    // START/STOP are SDA edges while SCL is high on both sides of the edge.
    assign start_det =  scl_s2 &  scl_d &  sda_d & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_d & ~sda_d &  sda_s2;

    // -----------------------------------------------------------------------
    // Protocol state
    // -----------------------------------------------------------------------
    state_t     state;
    logic [3:0] bit_cnt;   // SCL rises seen in the current byte/ACK slot
    logic [7:0] shreg;     // receive shift register / transmit byte
    logic [3:0] ptr;       // register pointer, wraps 15 -> 0
    logic       rw;        // R/W bit of the last matched address byte
    logic       wrote;     // a register was written since the last STOP

    logic [7:0] regs [16];

    // Byte as it stands once the current SDA sample is shifted in; at the
    // 8th rise of a WDATA byte this is the complete received byte.
    logic [7:0] rx_byte;
    logic       i2c_we;

    assign rx_byte = {shreg[6:0], sda_s2};
    assign i2c_we  = (state == WDATA) && scl_rise && (bit_cnt == 4'd7);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            ptr       <= 4'd0;
            rw        <= 1'b0;
            wrote     <= 1'b0;
            sda_dir_o <= 1'b0;
            busy_o    <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            irq_o <= 1'b0;

            if (stop_det) begin
                state     <= IDLE;
                bit_cnt   <= 4'd0;
                sda_dir_o <= 1'b0;
                busy_o    <= 1'b0;
                irq_o     <= wrote;
                wrote     <= 1'b0;
            end else if (start_det) begin
                // Also covers repeated START from any state.
                state     <= ADDR;
                bit_cnt   <= 4'd0;
                sda_dir_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        // Bus activity other than START is ignored.
                    end

                    // Receive a byte MSB first; act on it at the SCL fall
                    // that follows the 8th rise, which opens the ACK slot.
                    ADDR, PTR, WDATA: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (i2c_we) begin
                                ptr   <= ptr + 4'd1;
                                wrote <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR) begin
                                if (shreg[7:1] == SLV_ADDR) begin
                                    state     <= ADDR_ACK;
                                    sda_dir_o <= 1'b1;
                                    busy_o    <= 1'b1;
                                    rw        <= shreg[0];
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (state == PTR) begin
                                ptr       <= shreg[3:0];
                                state     <= PTR_ACK;
                                sda_dir_o <= 1'b1;
                            end else begin
                                state     <= WDATA_ACK;
                                sda_dir_o <= 1'b1;
                            end
                        end
                    end

                    // ACK slot: hold SDA low through the 9th clock and leave
                    // on the SCL fall after the 9th rise.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                        if (scl_rise) begin
                            bit_cnt <= 4'd1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            bit_cnt <= 4'd0;
                            if (state == ADDR_ACK && rw) begin
                                state     <= RDATA;
                                shreg     <= regs[ptr];
                                sda_dir_o <= ~regs[ptr][7];
                            end else if (state == ADDR_ACK) begin
                                state     <= PTR;
                                sda_dir_o <= 1'b0;
                            end else begin
                                state     <= WDATA;
                                sda_dir_o <= 1'b0;
                            end
                        end
                    end

                    // Transmit: shreg[7] is on the bus; each SCL fall moves
                    // to the next bit, and the fall after the 8th rise
                    // releases SDA for the master's ACK.
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt != 4'd0) begin
                            if (bit_cnt == 4'd8) begin
                                state     <= RDATA_ACK;
                                bit_cnt   <= 4'd0;
                                sda_dir_o <= 1'b0;
                            end else begin
                                shreg     <= {shreg[6:0], 1'b0};
                                sda_dir_o <= ~shreg[6];
                            end
                        end
                    end

                    // Master ACK advances the pointer and queues the next
                    // byte; NACK ends the read without driving the bus.
                    RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_s2) begin
                                ptr     <= ptr + 4'd1;
                                bit_cnt <= 4'd1;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state     <= RDATA;
                            bit_cnt   <= 4'd0;
                            shreg     <= regs[ptr];
                            sda_dir_o <= ~regs[ptr][7];
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        sda_dir_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Register bank
    // -----------------------------------------------------------------------
    // NOTE: the bank is reset explicitly because its contents are visible
    // state after reset; this keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (reg_we_i) begin
                regs[reg_addr_i] <= reg_wdata_i;
            end
            // Later assignment wins, so an I2C write overrides a host write
            // to the same register while a host write elsewhere still lands.
            if (i2c_we) begin
                regs[ptr] <= rx_byte;
            end
        end
    end

    assign reg_rdata_o = regs[reg_addr_i];
    assign sda_o       = 1'b0;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
//
// Bit-level I2C master driving i2c_target_regs over an open-drain bus, with
// a transaction-level model of the register bank and pointer. Directed
// scenarios cover write, read with wrap, address mismatch, host/I2C
// collisions and reset mid-read; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

    localparam int Q = 5;  // quarter SCL period in clk_i cycles

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_o;
    logic       sda_dir_o;
    logic [3:0] reg_addr_i;
    logic [7:0] reg_wdata_i;
    logic       reg_we_i;
    logic [7:0] reg_rdata_o;
    logic       busy_o;
    logic       irq_o;

    always #5 clk_i = ~clk_i;

    // Open-drain bus with pull-up.
    assign sda_line = sda_m & ~sda_dir_o;

    i2c_target_regs #(.SLV_ADDR(7'h50)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .scl_i       (scl_m),
        .sda_i       (sda_line),
        .sda_o       (sda_o),
        .sda_dir_o   (sda_dir_o),
        .reg_addr_i  (reg_addr_i),
        .reg_wdata_i (reg_wdata_i),
        .reg_we_i    (reg_we_i),
        .reg_rdata_o (reg_rdata_o),
        .busy_o      (busy_o),
        .irq_o       (irq_o)
    );

    int errors = 0;
    int checks = 0;

    // Event counters, only written here.
    int irq_cnt  = 0;
    int dir_cnt  = 0;
    int busy_cnt = 0;
    always @(posedge clk_i) begin
        if (irq_o === 1'b1)     irq_cnt++;
        if (sda_dir_o === 1'b1) dir_cnt++;
        if (busy_o === 1'b1)    busy_cnt++;
    end

    // Reference model: register bank contents and pointer.
    logic [7:0] m_regs [16];
    logic [3:0] m_ptr;
    logic [7:0] wq [$];   // data bytes for the next write transaction
    logic [7:0] rq [$];   // bytes captured by the last read transaction

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr = 4'd0;
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk_i);
        reg_addr_i  = a;
        reg_wdata_i = d;
        reg_we_i    = 1'b1;
        @(negedge clk_i);
        reg_we_i    = 1'b0;
        m_regs[a]   = d;
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
        @(negedge clk_i);
        reg_addr_i = a;
        #1;
        v = reg_rdata_o;
    endtask

    task automatic check_all_regs(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            read_reg(i[3:0], v);
            check($sformatf("%s reg[%0d]", tag, i), v, m_regs[i]);
        end
    endtask

    // Master bus primitives. Every primitive leaves SCL low except STOP.
    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    // Sends a byte and returns the sampled ACK (0 = ACK). With collide set,
    // a host write is placed in the clk_i cycle in which the target stores
    // the 8th bit (3 cycles after the SCL pin rises).
    task automatic write_byte(input logic [7:0] b, input logic collide,
                              input logic [3:0] h_addr, input logic [7:0] h_data,
                              output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i];
            wait_clk(Q);
            scl_m = 1'b1;
            for (int k = 1; k <= 2 * Q; k++) begin
                @(negedge clk_i);
                if (collide && i == 0 && k == 2) begin
                    reg_addr_i  = h_addr;
                    reg_wdata_i = h_data;
                    reg_we_i    = 1'b1;
                end
                if (k == 3) reg_we_i = 1'b0;
            end
            scl_m = 1'b0;
            wait_clk(Q);
        end
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        ack = sda_line;
        wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    // Reads a byte; ack_bit=1 answers ACK, 0 answers NACK.
    task automatic read_byte(input logic ack_bit, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_clk(Q);
            scl_m = 1'b1; wait_clk(Q);
            b[i] = sda_line;
            wait_clk(Q);
            scl_m = 1'b0; wait_clk(Q);
        end
        sda_m = ~ack_bit; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    // START, address write, pointer, bytes of wq, STOP.
    task automatic do_write(input string tag, input logic [7:0] ptr_byte);
        logic ack;
        int   irq0;
        irq0 = irq_cnt;
        i2c_start();
        write_byte(8'hA0, 1'b0, 4'h0, 8'h00, ack);
        check({tag, " addr ack"}, {7'd0, ack}, 8'h00);
        write_byte(ptr_byte, 1'b0, 4'h0, 8'h00, ack);
        check({tag, " ptr ack"}, {7'd0, ack}, 8'h00);
        m_ptr = ptr_byte[3:0];
        foreach (wq[j]) begin
            write_byte(wq[j], 1'b0, 4'h0, 8'h00, ack);
            check($sformatf("%s data%0d ack", tag, j), {7'd0, ack}, 8'h00);
            m_regs[m_ptr] = wq[j];
            m_ptr = m_ptr + 4'd1;
        end
        check({tag, " busy before stop"}, {7'd0, busy_o}, 8'h01);
        i2c_stop();
        wait_clk(6);
        check({tag, " busy after stop"}, {7'd0, busy_o}, 8'h00);
        check({tag, " irq pulses"}, 8'(irq_cnt - irq0), (wq.size() > 0) ? 8'd1 : 8'd0);
    endtask

    // Optional pointer set + repeated START, then read n bytes (ACK all but
    // the last), STOP. Captured bytes go to rq.
    task automatic do_read(input string tag, input logic set_ptr,
                           input logic [7:0] ptr_byte, input int n);
        logic       ack;
        logic [7:0] b;
        int         irq0;
        irq0 = irq_cnt;
        rq.delete();
        i2c_start();
        if (set_ptr) begin
            write_byte(8'hA0, 1'b0, 4'h0, 8'h00, ack);
            check({tag, " waddr ack"}, {7'd0, ack}, 8'h00);
            write_byte(ptr_byte, 1'b0, 4'h0, 8'h00, ack);
            check({tag, " ptr ack"}, {7'd0, ack}, 8'h00);
            m_ptr = ptr_byte[3:0];
            i2c_start();
        end
        write_byte(8'hA1, 1'b0, 4'h0, 8'h00, ack);
        check({tag, " raddr ack"}, {7'd0, ack}, 8'h00);
        for (int j = 0; j < n; j++) begin
            read_byte(j < n - 1, b);
            rq.push_back(b);
            check($sformatf("%s byte%0d", tag, j), b, m_regs[m_ptr]);
            if (j < n - 1) m_ptr = m_ptr + 4'd1;
        end
        i2c_stop();
        wait_clk(6);
        check({tag, " busy after stop"}, {7'd0, busy_o}, 8'h00);
        check({tag, " no irq"}, 8'(irq_cnt - irq0), 8'd0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] v;
        int         dir0;
        int         busy0;

        rst_i       = 1'b1;
        scl_m       = 1'b1;
        sda_m       = 1'b1;
        reg_addr_i  = 4'h0;
        reg_wdata_i = 8'h00;
        reg_we_i    = 1'b0;
        model_reset();
        wait_clk(5);
        rst_i = 1'b0;
        wait_clk(2);

        // Reset state
        check("reset sda_dir", {7'd0, sda_dir_o}, 8'h00);
        check("reset busy", {7'd0, busy_o}, 8'h00);
        check("reset irq", {7'd0, irq_o}, 8'h00);
        check("sda_o const", {7'd0, sda_o}, 8'h00);
        check_all_regs("reset");

        // Write sequence: 0xA0, 0x03, 0x11, 0x22
        wq = '{8'h11, 8'h22};
        do_write("wr", 8'h03);
        read_reg(4'd3, v);
        check("wr reg3", v, 8'h11);
        read_reg(4'd4, v);
        check("wr reg4", v, 8'h22);

        // Read sequence with pointer wrap
        host_write(4'd15, 8'h5A);
        host_write(4'd0, 8'hC3);
        do_read("rd", 1'b1, 8'h0F, 2);
        check("rd first", rq[0], 8'h5A);
        check("rd wrap", rq[1], 8'hC3);

        // Address mismatch: nothing driven, no busy, bank untouched
        dir0  = dir_cnt;
        busy0 = busy_cnt;
        i2c_start();
        write_byte(8'hA2, 1'b0, 4'h0, 8'h00, ack);
        check("mismatch nack", {7'd0, ack}, 8'h01);
        write_byte(8'h07, 1'b0, 4'h0, 8'h00, ack);
        check("mismatch byte2 nack", {7'd0, ack}, 8'h01);
        i2c_stop();
        wait_clk(6);
        check("mismatch sda_dir cycles", 8'(dir_cnt - dir0), 8'd0);
        check("mismatch busy cycles", 8'(busy_cnt - busy0), 8'd0);
        check_all_regs("mismatch");

        // Collisions: same register (I2C wins), different register (both land)
        i2c_start();
        write_byte(8'hA0, 1'b0, 4'h0, 8'h00, ack);
        check("col addr ack", {7'd0, ack}, 8'h00);
        write_byte(8'h05, 1'b0, 4'h0, 8'h00, ack);
        check("col ptr ack", {7'd0, ack}, 8'h00);
        write_byte(8'h12, 1'b1, 4'd5, 8'hFF, ack);
        check("col same ack", {7'd0, ack}, 8'h00);
        write_byte(8'h34, 1'b1, 4'd9, 8'h77, ack);
        check("col diff ack", {7'd0, ack}, 8'h00);
        i2c_stop();
        wait_clk(6);
        m_regs[5] = 8'h12;
        m_regs[9] = 8'h77;
        m_regs[6] = 8'h34;
        m_ptr     = 4'd7;
        read_reg(4'd5, v);
        check("col reg5 i2c wins", v, 8'h12);
        read_reg(4'd9, v);
        check("col reg9 host", v, 8'h77);
        read_reg(4'd6, v);
        check("col reg6 i2c", v, 8'h34);

        // Reset during RDATA bit 4 of an all-zero byte (target pulls SDA low)
        host_write(m_ptr, 8'h00);
        i2c_start();
        write_byte(8'hA1, 1'b0, 4'h0, 8'h00, ack);
        check("rst raddr ack", {7'd0, ack}, 8'h00);
        sda_m = 1'b1;
        for (int i = 7; i > 4; i--) begin
            wait_clk(Q);
            scl_m = 1'b1; wait_clk(2 * Q);
            scl_m = 1'b0; wait_clk(Q);
        end
        wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        check("rst bit4 driven", {7'd0, sda_dir_o}, 8'h01);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("rst sda_dir next cycle", {7'd0, sda_dir_o}, 8'h00);
        check("rst busy", {7'd0, busy_o}, 8'h00);
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        dir0 = dir_cnt;
        // Leftover clocks with no START must be ignored.
        scl_m = 1'b0; wait_clk(Q);
        for (int i = 0; i < 4; i++) begin
            sda_m = 1'($urandom_range(0, 1));
            wait_clk(Q);
            scl_m = 1'b1; wait_clk(2 * Q);
            scl_m = 1'b0; wait_clk(Q);
        end
        i2c_stop();
        wait_clk(6);
        check("post-rst ignored", 8'(dir_cnt - dir0), 8'd0);
        check_all_regs("post-rst");
        wq = '{8'h99};
        do_write("post-rst wr", 8'h02);
        read_reg(4'd2, v);
        check("post-rst reg2", v, 8'h99);

        // Randomized phase
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                host_write(4'($urandom_range(0, 15)), 8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) begin
                wq.delete();
                repeat ($urandom_range(0, 4)) wq.push_back(8'($urandom));
                do_write($sformatf("rnd%0d wr", t), 8'($urandom));
            end else begin
                do_read($sformatf("rnd%0d rd", t), 1'($urandom_range(0, 1)),
                        8'($urandom), $urandom_range(1, 3));
            end
        end
        check_all_regs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
